cactus_spawner: RTL and testbench



---
 rtl/dino_pkg.sv | 29 ++
 rtl/cactus_slot.sv | 70 +++++++
 rtl/cactus_spawner.sv | 136 +++++++++++++
 tb/tb_cactus_spawner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dino_pkg
// Brief    : Shared constants and types for the cactus obstacle subsystem.
// Revision : 1.0 - initial release
// ============================================================================
package dino_pkg;

  localparam int X_W       = 10;   // x-coordinate width
  localparam int SCREEN_X  = 640;  // right edge; new cacti appear here
  localparam int MIN_GAP   = 96;   // minimum pixels between spawns
  localparam int GAP_SHIFT = 5;    // scale for the random extra gap

  // Cactus shapes as seen by the renderer and collision logic
  typedef enum logic [1:0] {
    CACTUS_SMALL  = 2'd0,
    CACTUS_TALL   = 2'd1,
    CACTUS_DOUBLE = 2'd2,
    CACTUS_WIDE   = 2'd3
  } cactus_type_e;

  // FETCH: waiting for a random sample; ARMED: counting down to a spawn
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ARMED = 1'b1
  } spawn_state_e;

endpackage : dino_pkg
`default_nettype wire

// File: rtl/cactus_slot.sv
`default_nettype none
// ============================================================================
// Module   : cactus_slot
// Brief    : One on-screen cactus: valid/x/type registers with scroll, free
//            (on leaving the screen) and load (spawn at the right edge).
// Revision : 1.0 - initial release
// ============================================================================
module cactus_slot #(
  parameter int X_W      = dino_pkg::X_W,
  parameter int SCREEN_X = dino_pkg::SCREEN_X
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  input  logic           move_i,
  input  logic [3:0]     speed_i,
  input  logic           load_i,
  input  logic [1:0]     load_type_i,
  output logic           valid_o,
  output logic [X_W-1:0] x_o,
  output logic [1:0]     type_o
);

  logic           valid_q, valid_d;
  logic [X_W-1:0] x_q, x_d;
  logic [1:0]     type_q, type_d;
  logic [X_W-1:0] w_speed;

  assign w_speed = X_W'(speed_i);

  // Next-state: clear beats load; a freshly loaded slot is not scrolled.
  // A slot whose x is smaller than the step leaves the screen and is freed.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    type_d  = type_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      x_d     = X_W'(SCREEN_X);
      type_d  = load_type_i;
    end else if (move_i && valid_q) begin
      if (x_q < w_speed) begin
        valid_d = 1'b0;
      end else begin
        x_d = x_q - w_speed;
      end
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      type_q  <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      type_q  <= type_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign type_o  = type_q;

endmodule : cactus_slot
`default_nettype wire

// File: rtl/cactus_spawner.sv
`default_nettype none
// ============================================================================
// Module   : cactus_spawner
// Brief    : Fetches random samples, turns each into a cactus type and spawn
//            gap, and maintains a small table of scrolling cacti.
// Revision : 1.0 - initial release
// ============================================================================
module cactus_spawner #(
  parameter int RAND_W    = 5,
  parameter int NUM_SLOTS = 4,
  parameter int X_W       = dino_pkg::X_W,
  parameter int SCREEN_X  = dino_pkg::SCREEN_X,
  parameter int MIN_GAP   = dino_pkg::MIN_GAP,
  parameter int GAP_SHIFT = dino_pkg::GAP_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     run,
  input  logic                     clear,
  input  logic [3:0]               speed,
  output logic                     rand_req,
  input  logic                     rand_valid,
  input  logic [RAND_W-1:0]        rand_data,
  output logic [NUM_SLOTS-1:0]     cactus_valid,
  output logic [NUM_SLOTS*X_W-1:0] cactus_x,
  output logic [NUM_SLOTS*2-1:0]   cactus_type
);

  import dino_pkg::*;

  // Gap is one bit wider than x so MIN_GAP + (7 << GAP_SHIFT) fits
  localparam int GAP_W = X_W + 1;

  spawn_state_e          state_q, state_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [1:0]            pend_q, pend_d;
  logic                  rand_req_q, rand_req_d;

  logic                  w_move;
  logic                  w_spawn;
  logic [GAP_W-1:0]      w_speed;
  logic [GAP_W-1:0]      w_new_gap;
  logic [NUM_SLOTS-1:0]  w_valid;
  logic [NUM_SLOTS-1:0]  w_free;
  logic [NUM_SLOTS-1:0]  w_lowest_free;
  logic [NUM_SLOTS-1:0]  w_load;

  assign w_move    = tick & run;
  assign w_speed   = GAP_W'(speed);
  assign w_new_gap = GAP_W'(MIN_GAP) + (GAP_W'(rand_data[4:2]) << GAP_SHIFT);

  // Lowest-index free slot as a one-hot vector (isolate lowest set bit)
  always_comb begin
    w_free        = ~w_valid;
    w_lowest_free = w_free & (~w_free + NUM_SLOTS'(1));
  end

  assign w_load = w_spawn ? w_lowest_free : '0;

  // Spawner FSM next-state: handshake in FETCH, countdown/spawn in ARMED
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    w_spawn = 1'b0;
    if (clear) begin
      state_d = FETCH;
      gap_d   = '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (rand_req_q && rand_valid) begin
            pend_d  = rand_data[1:0];
            gap_d   = w_new_gap;
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (w_move) begin
            if (gap_q != '0) begin
              gap_d = (gap_q <= w_speed) ? '0 : (gap_q - w_speed);
            end else if (|w_free) begin
              w_spawn = 1'b1;
              state_d = FETCH;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
    // Request is held for every cycle spent in FETCH
    rand_req_d = (state_d == FETCH);
  end

  // Spawner state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      gap_q      <= '0;
      pend_q     <= '0;
      rand_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      pend_q     <= pend_d;
      rand_req_q <= rand_req_d;
    end
  end

  assign rand_req = rand_req_q;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      cactus_slot #(
        .X_W      (X_W),
        .SCREEN_X (SCREEN_X)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .move_i      (w_move),
        .speed_i     (speed),
        .load_i      (w_load[i]),
        .load_type_i (pend_q),
        .valid_o     (w_valid[i]),
        .x_o         (cactus_x[i*X_W +: X_W]),
        .type_o      (cactus_type[i*2 +: 2])
      );
    end
  endgenerate

  assign cactus_valid = w_valid;

endmodule : cactus_spawner
`default_nettype wire

// File: tb/tb_cactus_spawner.sv
`default_nettype none
// ============================================================================
// Module   : tb_cactus_spawner
// Brief    : Scoreboard bench for cactus_spawner against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cactus_spawner;

  localparam int NS = 4;
  localparam int XW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              run = 1'b0;
  logic              clear = 1'b0;
  logic [3:0]        speed = '0;
  logic              rand_req;
  logic              rand_valid = 1'b0;
  logic [4:0]        rand_data = '0;
  logic [NS-1:0]     cactus_valid;
  logic [NS*XW-1:0]  cactus_x;
  logic [NS*2-1:0]   cactus_type;

  cactus_spawner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .run          (run),
    .clear        (clear),
    .speed        (speed),
    .rand_req     (rand_req),
    .rand_valid   (rand_valid),
    .rand_data    (rand_data),
    .cactus_valid (cactus_valid),
    .cactus_x     (cactus_x),
    .cactus_type  (cactus_type)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0]    v;
    logic [NS*XW-1:0] x;
    logic [NS*2-1:0]  t;
    logic             req;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: game-level view of the table and spawn timer
  bit m_valid[NS];
  int m_x[NS];
  int m_type[NS];
  int m_gap;
  int m_pend;
  bit m_waiting;   // a sample has been taken and a spawn is pending
  bit m_req;

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_x[i] = 0; m_type[i] = 0;
    end
    m_gap = 0; m_pend = 0; m_waiting = 0; m_req = 0;
  endfunction

  function automatic void model_step(bit tk, bit rn, bit cl, int sp, bit rv, int rd);
    bit was_valid[NS];
    int target;
    bit frame;
    if (cl) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 0;
      m_gap = 0; m_waiting = 0; m_req = 1;
      return;
    end
    frame  = tk && rn;
    target = -1;
    for (int i = 0; i < NS; i++) was_valid[i] = m_valid[i];
    if (!m_waiting) begin
      if (m_req && rv) begin
        m_pend    = rd % 4;
        m_gap     = 96 + (rd / 4) * 32;
        m_waiting = 1;
      end
    end else if (frame) begin
      if (m_gap != 0) begin
        m_gap = (m_gap <= sp) ? 0 : m_gap - sp;
      end else begin
        for (int i = NS - 1; i >= 0; i--) if (!was_valid[i]) target = i;
      end
    end
    if (frame) begin
      for (int i = 0; i < NS; i++) begin
        if (was_valid[i]) begin
          if (m_x[i] < sp) m_valid[i] = 0;
          else m_x[i] = m_x[i] - sp;
        end
      end
    end
    if (target >= 0) begin
      m_valid[target] = 1;
      m_x[target]     = 640;
      m_type[target]  = m_pend;
      m_waiting       = 0;
    end
    m_req = !m_waiting;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      e.v[i]           = m_valid[i];
      e.x[i*XW +: XW]  = XW'(m_x[i]);
      e.t[i*2 +: 2]    = 2'(m_type[i]);
    end
    e.req = m_req;
    return e;
  endfunction

  // One clock of stimulus; the expected state after the next edge is queued
  task automatic cyc(input bit rn, input bit tk, input bit rr, input bit cl,
                     input logic [3:0] sp, input bit rv, input logic [4:0] rd);
    @(negedge clk);
    #1;
    rst_n = rn; tick = tk; run = rr; clear = cl; speed = sp;
    rand_valid = rv; rand_data = rd;
    if (!rn) model_reset();
    else model_step(tk, rr, cl, int'(sp), rv, int'(rd));
    q.push_back(snap());
  endtask

  // Monitor: pop the expected state and compare every output group
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [NS*XW-1:0] xm;
      logic [NS*2-1:0]  tm;
      e  = q.pop_front();
      xm = '0; tm = '0;
      for (int i = 0; i < NS; i++) begin
        if (e.v[i]) begin
          xm[i*XW +: XW] = '1;
          tm[i*2 +: 2]   = '1;
        end
      end
      n_cmp += 4;
      if (rand_req !== e.req) begin
        n_err++;
        $display("FAIL rand_req t=%0t actual=%b required=%b", $time, rand_req, e.req);
      end
      if (cactus_valid !== e.v) begin
        n_err++;
        $display("FAIL valid t=%0t actual=%b required=%b", $time, cactus_valid, e.v);
      end
      if ((cactus_x & xm) !== (e.x & xm)) begin
        n_err++;
        $display("FAIL x t=%0t actual=%h required=%h", $time, cactus_x & xm, e.x & xm);
      end
      if ((cactus_type & tm) !== (e.t & tm)) begin
        n_err++;
        $display("FAIL type t=%0t actual=%h required=%h", $time, cactus_type & tm, e.t & tm);
      end
    end
  end

  initial begin
    // Reset held with ticks arriving
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 4'd8, 1, 5'd3);
    model_reset();

    // First spawn: sample 00001 at speed 8 -> gap 96, type 1
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 4'd8, (i == 1), 5'b00001);

    // Gap decode: sample 10110 at speed 7 -> type 2, gap 256
    for (int i = 0; i < 45; i++) cyc(1, 1, 1, 0, 4'd7, 1, 5'b10110);

    // Handshake stall: sample withheld while cacti keep scrolling
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 4'd8, 0, 5'd0);
    cyc(1, 1, 1, 0, 4'd8, 1, 5'b00011);

    // Clear with a sample offered on the same cycle
    cyc(1, 0, 1, 1, 4'd8, 1, 5'b11111);
    cyc(1, 0, 1, 0, 4'd8, 0, 5'd0);
    cyc(1, 0, 1, 0, 4'd8, 0, 5'd0);

    // Full table: slow scroll, minimum gaps, deferred spawn then slot reuse
    for (int i = 0; i < 800; i++) cyc(1, 1, 1, 0, 4'd1, 1, 5'(i % 4));

    // Speed 0 and run = 0 freeze scenes
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 4'd0, 1, 5'd5);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 4'd9, 1, 5'd6);

    // Randomized play, with a mid-run asynchronous reset
    for (int i = 0; i < 6000; i++) begin
      bit rn;
      rn = !(i >= 3000 && i < 3003);
      cyc(rn, ($urandom % 2) == 0, ($urandom % 10) != 0, ($urandom % 700) == 0,
          4'($urandom_range(0, 15)), ($urandom % 3) == 0, 5'($urandom));
    end

    cyc(1, 0, 1, 0, 4'd0, 0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cactus_spawner
`default_nettype wire
